// File: rtl/mem_bus_pkg.sv
// Shared types and lane-enable constants for the memory bus sequencer.
// Used by mem_bus_sequencer and bus_lane_steer.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER0 = 2'd1,
    XFER1 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  // Widen a read byte to 16 bits, replicating bit 7 when sign extension is asked for.
  function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sext);
    extend_byte = {(sext ? {8{b[7]}} : 8'h00), b};
  endfunction

endpackage

// File: rtl/bus_lane_steer.sv
// Combinational byte-lane steering for writes, lane capture selection for reads,
// and final read merge/extension for the memory bus sequencer.
module bus_lane_steer
  import mem_bus_pkg::*;
(
  input  logic        word,
  input  logic        odd,
  input  logic        second,
  input  logic        sext,
  input  logic [15:0] wdata,
  input  logic [15:0] mem_rdata,
  input  logic [7:0]  res_lo,
  input  logic [7:0]  res_hi,
  output logic [1:0]  be,
  output logic [15:0] lane_wdata,
  output logic [7:0]  cap_lo,
  output logic [7:0]  cap_hi,
  output logic [15:0] result
);

  // The second half of a split word always lands on the even lane of the next word.
  always_comb begin
    be         = BE_LO;
    lane_wdata = {8'h00, wdata[7:0]};
    if (second) begin
      be         = BE_LO;
      lane_wdata = {8'h00, wdata[15:8]};
    end else if (word && !odd) begin
      be         = BE_WORD;
      lane_wdata = wdata;
    end else if (odd) begin
      be         = BE_HI;
      lane_wdata = {wdata[7:0], 8'h00};
    end
  end

  always_comb begin
    cap_lo = odd ? mem_rdata[15:8] : mem_rdata[7:0];
    cap_hi = second ? mem_rdata[7:0] : mem_rdata[15:8];
    result = word ? {res_hi, res_lo} : extend_byte(res_lo, sext);
  end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Two-port arbiter and sequencer in front of a 16-bit little-endian memory port.
// Define MEM_SEQ_ROUND_ROBIN_EN for alternating tie-break; default is fixed priority to port 1.
module mem_bus_sequencer
  import mem_bus_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          word0,
  input  logic          word1,
  input  logic          sext0,
  input  logic          sext1,
  input  logic          we1,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    ack,
  output logic [DW-1:0] rdata,
  output logic          mem_valid,
  output logic [AW-2:0] mem_addr,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready
);

  state_t        state, state_next;
  logic          h_port;
  logic [AW-1:0] h_addr;
  logic          h_word;
  logic          h_sext;
  logic          h_we;
  logic [DW-1:0] h_wdata;
  logic [7:0]    res_lo;
  logic [7:0]    res_hi;
  logic          grant1;
  logic          split;
  logic [AW-2:0] word_addr;
  logic [1:0]    lane_be;
  logic [DW-1:0] lane_wdata;
  logic [7:0]    cap_lo;
  logic [7:0]    cap_hi;
  logic [DW-1:0] result;

  assign split     = h_word & h_addr[0];
  assign word_addr = h_addr[AW-1:1];

`ifdef MEM_SEQ_ROUND_ROBIN_EN
  logic last_grant;

  // On a tie, hand the grant to whichever port did not win last time.
  assign grant1 = req[1] && !(req[0] && last_grant);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b0;
    end else if (state == IDLE && req != 2'b00) begin
      last_grant <= grant1;
    end
  end
`else
  assign grant1 = req[1];
`endif

  bus_lane_steer u_steer (
    .word       (h_word),
    .odd        (h_addr[0]),
    .second     (state == XFER1),
    .sext       (h_sext),
    .wdata      (h_wdata),
    .mem_rdata  (mem_rdata),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .cap_lo     (cap_lo),
    .cap_hi     (cap_hi),
    .result     (result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      h_port  <= 1'b0;
      h_addr  <= '0;
      h_word  <= 1'b0;
      h_sext  <= 1'b0;
      h_we    <= 1'b0;
      h_wdata <= '0;
      res_lo  <= 8'h00;
      res_hi  <= 8'h00;
    end else begin
      state <= state_next;
      if (state == IDLE && req != 2'b00) begin
        h_port  <= grant1;
        h_addr  <= grant1 ? addr1 : addr0;
        h_word  <= grant1 ? word1 : word0;
        h_sext  <= grant1 ? sext1 : sext0;
        h_we    <= grant1 & we1;
        h_wdata <= grant1 ? wdata1 : '0;
        res_lo  <= 8'h00;
        res_hi  <= 8'h00;
      end
      // Split reads overwrite the high byte again in the second cycle.
      if (state == XFER0 && mem_ready) begin
        res_lo <= cap_lo;
        res_hi <= cap_hi;
      end
      if (state == XFER1 && mem_ready) begin
        res_hi <= cap_hi;
      end
    end
  end

  always_comb begin
    state_next = state;
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 2'b00;
    mem_addr   = '0;
    mem_wdata  = '0;
    ack        = 2'b00;
    rdata      = '0;
    case (state)
      IDLE: begin
        if (req != 2'b00) state_next = XFER0;
      end
      XFER0: begin
        mem_valid = 1'b1;
        mem_we    = h_we;
        mem_be    = lane_be;
        mem_addr  = word_addr;
        mem_wdata = h_we ? lane_wdata : '0;
        if (mem_ready) state_next = split ? XFER1 : RESP;
      end
      XFER1: begin
        mem_valid = 1'b1;
        mem_we    = h_we;
        mem_be    = lane_be;
        mem_addr  = word_addr + (AW-1)'(1);
        mem_wdata = h_we ? lane_wdata : '0;
        if (mem_ready) state_next = RESP;
      end
      RESP: begin
        ack        = h_port ? 2'b10 : 2'b01;
        rdata      = h_we ? '0 : result;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
